bpsk_phase_gen: RTL
===================

Name: bpsk_phase_gen

Overview:
Upstream feeder for the CORDIC sine/cosine stage in the BPSK modulator. It accepts data bits over a valid/ready handshake and holds each bit for SPS sample ticks. A 32-bit carrier phase accumulator advances by a frequency tuning word, and 0 or pi is added per bit to form the CORDIC angle. It also delays the valid and symbol-start flags to line up with the CORDIC output samples.

Parameters:
SPS, 8, sample ticks per symbol (>=2)
CORDIC_LATENCY, 16, clock cycles from angle register to CORDIC sine/cosine output (1 + WIDTH-1 for WIDTH=16)
PHASE_W, 32, accumulator/angle width; fixed at 32 to match CORDIC angle port

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global run gate; low freezes all state except the delay line
sample_tick  in  1  one-cycle strobe, one output sample per tick
ftw  in  32  carrier frequency tuning word, unsigned; full scale 2^32 = 2*pi
bit_data  in  1  data bit to modulate
bit_valid  in  1  bit_data is valid
bit_ready  out  1  block accepts bit this cycle
angle  out  32  registered CORDIC angle, signed 2's-complement phase
angle_valid  out  1  angle carries a modulated sample (one cycle per tick)
sym_start  out  1  angle is first sample of a symbol
out_valid  out  1  angle_valid delayed CORDIC_LATENCY cycles
out_sym_start  out  1  sym_start delayed CORDIC_LATENCY cycles

Behaviour:
- Reset (async): phase=0, angle=0, state=IDLE, sample count=0, cur_bit=0, all flags 0, delay line cleared. bit_ready=1 after reset (IDLE).
- States IDLE, RUN.
- A tick is active when enable & sample_tick. Phase accumulator: phase <= phase + ftw (mod 2^32) on every active tick in both states, so the carrier is continuous.
- IDLE: bit_ready=1 combinationally. On bit_valid & bit_ready: latch cur_bit, count=0, go RUN. No angle_valid in IDLE.
- RUN: on each active tick: angle <= phase + ftw + (flip ? 32'h8000_0000 : 0); angle_valid=1 for that cycle; sym_start=1 when count==0; count++.
- bit_ready in RUN = (count==SPS-1) & active tick. This gives back-to-back symbols with no gap.
- Last tick of a symbol (count==SPS-1) with handshake: latch the new bit, count=0, stay RUN. Without handshake: go IDLE.
- angle and the flags update one cycle after the tick (registered). Between ticks, angle holds and angle_valid/sym_start=0.
- enable=0: ticks ignored, all state held, bit_ready=0 in RUN. In IDLE, bit_ready stays 1, so a bit can be accepted while disabled.
- bit_valid in RUN when not ready: held off; the source must keep bit_data stable.
- Delay line: shift register CORDIC_LATENCY deep for {angle_valid, sym_start}, clocked every cycle regardless of enable.
- flip = cur_bit (bit 1 -> +pi).

Optional Feature:
BPSK_DIFF_EN: when defined, differential encoding is used: flip_reg <= flip_reg ^ bit on each accepted bit; flip_reg resets 0 and flip = flip_reg. When undefined, flip = cur_bit directly and no flip_reg exists.

Decomposition:
- Package bpsk_pkg holds:
  - PI_OFFSET = 32'h8000_0000
  - phase_gen state typedef (IDLE, RUN)
  - default CORDIC_LATENCY constant
- One sub-module: flag_delay_line (parameter DEPTH, WIDTH), a plain shift register with async reset, used for out_valid/out_sym_start.

Test Plan:
1. Reset and idle: assert reset mid-run at count 3 -> same cycle: angle=0, angle_valid=0, state IDLE, bit_ready=1; delay-line outputs cleared.
2. Single bit: SPS=4, ftw=0x0400_0000, tick every cycle, one bit 0 -> angles 0x0400_0000, 0x0800_0000, 0x0C00_0000, 0x1000_0000; sym_start only on the first; then IDLE, angle_valid=0.
3. Back-to-back bits 0 then 1: fifth angle = 0x9400_0000; angle_valid continuous; bit_ready pulses only on count 3.
4. Wrap: ftw=0x4000_0000, one bit 0, SPS=4 -> 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000.
5. Gating: sample_tick every 3rd cycle, enable low for 5 cycles mid-symbol -> no phase advance or count change while disabled; angle_valid only on the cycle after each active tick.
6. Alignment: out_valid/out_sym_start equal angle_valid/sym_start delayed exactly 16 cycles. With BPSK_DIFF_EN, bits 1,1,0 -> flip 1,0,0 (offsets pi, 0, 0).

Source files
------------

// File: rtl/bpsk_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_pkg
// Shared constants and types for the BPSK phase generator.
//   PI_OFFSET               : half-turn (pi) in 32-bit full-scale phase units
//   DEFAULT_CORDIC_LATENCY  : angle-register to sine/cosine output latency
//   phase_state_t           : symbol sequencer states (IDLE, RUN)
// -----------------------------------------------------------------------------
package bpsk_pkg;

  localparam logic [31:0] PI_OFFSET              = 32'h8000_0000;
  localparam int          DEFAULT_CORDIC_LATENCY = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } phase_state_t;

endpackage : bpsk_pkg

// File: rtl/flag_delay_line.sv
// -----------------------------------------------------------------------------
// flag_delay_line
// Plain DEPTH-stage shift register, WIDTH bits wide, advanced every clock.
// Used to line up per-sample flags with the CORDIC output samples.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-high; clears every stage
//   flags   : WIDTH-bit input word
//   delayed : flags delayed by exactly DEPTH clock cycles
// -----------------------------------------------------------------------------
module flag_delay_line #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset, not just the output one; otherwise stale flags
  // from before reset would emerge as phantom valid samples DEPTH cycles later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= flags;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule : flag_delay_line

// File: rtl/bpsk_phase_gen.sv
// -----------------------------------------------------------------------------
// bpsk_phase_gen
// Upstream feeder for the CORDIC sine/cosine stage of the BPSK modulator.
// Accepts data bits over valid/ready, holds each bit for SPS sample ticks,
// runs a continuous 32-bit carrier phase accumulator and adds 0 or pi per bit
// to form the CORDIC angle. Valid/symbol-start flags are also delayed by
// CORDIC_LATENCY cycles to line up with the CORDIC output samples.
//
// Configuration macro:
//   BPSK_DIFF_EN : when defined, differential encoding; the pi offset toggles
//                  on every accepted 1 bit (flip_reg <= flip_reg ^ bit).
//                  When undefined, the pi offset follows the current bit.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   enable        in   run gate; low freezes all state except the delay line
//   sample_tick   in   one-cycle strobe, one output sample per active tick
//   ftw           in   carrier frequency tuning word (2^32 = 2*pi)
//   bit_data      in   data bit to modulate
//   bit_valid     in   bit_data is valid
//   bit_ready     out  bit accepted this cycle when bit_valid is high
//   angle         out  registered CORDIC angle, signed 2's-complement phase
//   angle_valid   out  angle carries a modulated sample (one cycle per tick)
//   sym_start     out  angle is the first sample of a symbol
//   out_valid     out  angle_valid delayed CORDIC_LATENCY cycles
//   out_sym_start out  sym_start delayed CORDIC_LATENCY cycles
// -----------------------------------------------------------------------------
module bpsk_phase_gen
  import bpsk_pkg::*;
#(
  parameter int SPS            = 8,
  parameter int CORDIC_LATENCY = DEFAULT_CORDIC_LATENCY,
  parameter int PHASE_W        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               bit_data,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [PHASE_W-1:0] angle,
  output logic               angle_valid,
  output logic               sym_start,
  output logic               out_valid,
  output logic               out_sym_start
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

  phase_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_adv;
  logic             active;
  logic             last_sample;
  logic             accept;
  logic             emit;
  logic             flip;
  logic [1:0]       delayed_flags;

  assign active      = enable & sample_tick;
  assign last_sample = (count == CNT_W'(SPS - 1));
  assign phase_adv   = phase + ftw;

  // ---------------------------------------------------------------------------
  // Sequencer: next state, handshake and sample emission
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is assigned a default first so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    bit_ready  = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;

    unique case (state)
      IDLE: begin
        // Ready does not depend on enable: a bit may be loaded while disabled.
        bit_ready = 1'b1;
        if (bit_valid) begin
          accept     = 1'b1;
          count_next = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (active) begin
          emit = 1'b1;
          if (last_sample) begin
            // Offering ready only on the last tick lets the next symbol start
            // on the very next tick with no gap.
            bit_ready  = 1'b1;
            count_next = '0;
            if (bit_valid) begin
              accept = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            count_next = count + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-to-offset mapping
  // ---------------------------------------------------------------------------
`ifdef BPSK_DIFF_EN
  // Differential encoding: the accepted bit is folded into the running flip.
  logic flip_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flip_reg <= 1'b0;
    end else if (accept) begin
      flip_reg <= flip_reg ^ bit_data;
    end
  end

  assign flip = flip_reg;
`else
  logic cur_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_bit <= 1'b0;
    end else if (accept) begin
      cur_bit <= bit_data;
    end
  end

  assign flip = cur_bit;
`endif

  // ---------------------------------------------------------------------------
  // Carrier phase accumulator and angle register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
      sym_start   <= 1'b0;
    end else begin
      // Advance in both states so the carrier stays continuous across gaps.
      if (active) begin
        phase <= phase_adv;
      end
      // The angle uses the post-advance phase, i.e. the sample for this tick.
      if (emit) begin
        angle <= phase_adv + (flip ? PI_OFFSET : '0);
      end
      angle_valid <= emit;
      sym_start   <= emit & (count == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Flag alignment with the CORDIC output
  // ---------------------------------------------------------------------------
  flag_delay_line #(
    .DEPTH (CORDIC_LATENCY),
    .WIDTH (2)
  ) u_flag_delay_line (
    .clock   (clock),
    .reset   (reset),
    .flags   ({angle_valid, sym_start}),
    .delayed (delayed_flags)
  );

  assign out_valid     = delayed_flags[1];
  assign out_sym_start = delayed_flags[0];

endmodule : bpsk_phase_gen
